// File: rtl/add_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_accum_pkg
//  Purpose  : State encoding and port-width helpers for add_result_accum.
//  Revision : 1.0
// ============================================================================
package add_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Widest total: COUNT beats of (2^(BITS+1))-1 each.
   function automatic int calc_aw(input int bits, input int count);
      return bits + 1 + $clog2(count);
   endfunction

   function automatic int calc_cw(input int count);
      return $clog2(count + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/add_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : add_result_accum
//  Purpose  : Sums blocks of {carry,sum} adder beats and presents block totals.
//  Revision : 1.0
// ============================================================================
module add_result_accum
   import add_accum_pkg::*;
#(
   parameter int  BITS  = 4,
   parameter int  COUNT = 4,
   localparam int AW    = calc_aw(BITS, COUNT),
   localparam int CW    = calc_cw(COUNT)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          carry,
   input  logic [BITS-1:0] sum,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] total,
   output logic [CW-1:0] beats
);

   localparam logic [CW-1:0] c_count = CW'(COUNT);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_sync;
   logic          w_run;
   logic          w_accept;
   logic          w_last;
   logic [AW-1:0] w_beat;
   logic [CW-1:0] w_cnt_inc;

   // Reset release is retimed here; IDLE refuses beats until it has propagated.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_sync <= 2'b00;
      else          r_sync <= {r_sync[0], 1'b1};
   end

   assign w_run     = r_sync[1];
   assign w_beat    = AW'({carry, sum});
   assign w_accept  = in_valid & in_ready;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_last    = (w_cnt_inc == c_count) | flush;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = w_last ? HOLD : ACCUM;
         ACCUM:   if ((w_accept && w_last) || flush) w_state_nxt = HOLD;
         HOLD:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE:    in_ready  = w_run | ~reset_n;
         ACCUM:   in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == HOLD) begin
         if (out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
         end
      end else if (w_accept) begin
         r_acc <= (r_state == IDLE) ? w_beat : r_acc + w_beat;
         r_cnt <= w_cnt_inc;
      end
   end

   assign total = out_valid ? r_acc : '0;
   assign beats = out_valid ? r_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_add_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_result_accum
//  Purpose  : Directed and randomized checks of add_result_accum (BITS=4, COUNT=4).
//  Revision : 1.0
// ============================================================================
module tb_add_result_accum;
   import add_accum_pkg::*;

   localparam int BITS  = 4;
   localparam int COUNT = 4;
   localparam int AW    = calc_aw(BITS, COUNT);
   localparam int CW    = calc_cw(COUNT);

   logic            clock    = 1'b0;
   logic            reset_n  = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            carry    = 1'b0;
   logic [BITS-1:0] sum      = '0;
   logic            flush    = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [AW-1:0]   total;
   logic [CW-1:0]   beats;

   int n_tests = 0;
   int n_fail  = 0;

   add_result_accum #(.BITS(BITS), .COUNT(COUNT)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .carry(carry), .sum(sum), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .total(total), .beats(beats)
   );

   always #5 clock = ~clock;

   // Reference: the current block is a list of beat values plus a "presented" flag.
   int m_q[$];
   bit m_hold = 1'b0;
   int m_sync = 0;

   function automatic int m_total();
      int s = 0;
      foreach (m_q[i]) s += m_q[i];
      return s;
   endfunction

   function automatic bit m_in_ready();
      return !reset_n || (!m_hold && m_sync >= 2);
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_hold = 1'b0;
         m_sync = 0;
      end else begin
         bit acc;
         acc = in_valid && m_in_ready();
         if (m_hold) begin
            if (out_ready) begin
               m_q.delete();
               m_hold = 1'b0;
            end
         end else begin
            if (acc) m_q.push_back(int'({carry, sum}));
            if ((acc && (m_q.size() == COUNT || flush)) || (!acc && flush && m_q.size() > 0))
               m_hold = 1'b1;
         end
         if (m_sync < 2) m_sync++;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check("model_out_valid", int'(out_valid), int'(m_hold));
      check("model_in_ready", int'(in_ready), int'(m_in_ready()));
      check("model_total", int'(total), m_hold ? m_total() : 0);
      check("model_beats", int'(beats), m_hold ? m_q.size() : 0);
   end

   task automatic drive(input bit iv, input bit c, input bit [BITS-1:0] s,
                        input bit f, input bit ordy);
      @(posedge clock);
      #1;
      in_valid  = iv;
      carry     = c;
      sum       = s;
      flush     = f;
      out_ready = ordy;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      idle();
   endtask

   initial begin
      #2;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_total", int'(total), 0);
      check("rst_beats", int'(beats), 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) idle();

      // Four full-scale beats: 4 * 31.
      repeat (4) drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
      idle();
      @(negedge clock);
      check("full_out_valid", int'(out_valid), 1);
      check("full_total", int'(total), 124);
      check("full_beats", int'(beats), 4);

      // Backpressure: result stays put, upstream is stalled.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
         @(negedge clock);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_total", int'(total), 124);
         check("stall_beats", int'(beats), 4);
      end
      drain();
      @(negedge clock);
      check("drain_out_valid", int'(out_valid), 0);
      check("drain_in_ready", int'(in_ready), 1);
      check("drain_total", int'(total), 0);

      // Partial block closed by a bare flush.
      drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      check("flush_out_valid", int'(out_valid), 1);
      check("flush_total", int'(total), 8);
      check("flush_beats", int'(beats), 2);
      drain();

      // Flush together with a beat includes that beat.
      drive(1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      check("flushbeat_total", int'(total), 7);
      check("flushbeat_beats", int'(beats), 1);
      drain();

      // Flush in IDLE is ignored.
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      check("idleflush_valid", int'(out_valid), 0);
      idle();
      @(negedge clock);
      check("idleflush_valid2", int'(out_valid), 0);

      // Reset discards a pending result immediately.
      drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      check("prerst_total", int'(total), 2);
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_total", int'(total), 0);
      check("midrst_beats", int'(beats), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) idle();
      repeat (4) drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      idle();
      @(negedge clock);
      check("postrst_valid", int'(out_valid), 1);
      check("postrst_total", int'(total), 4);
      check("postrst_beats", int'(beats), 4);
      drain();

      // Randomized traffic, checked every cycle against the reference.
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
               1'($urandom_range(0, 1)));
      end
      drain();
      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
